// File: rtl/pixel_ser_pkg.sv
// Shared types and constants for the pixel-to-byte serializer.
// Lane constants name the colour channel position inside a {R,G,B} pixel.
package pixel_ser_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StByte0,
    StByte1,
    StByte2
  } ser_state_e;

  localparam logic [1:0] ByteIdx0 = 2'd0;
  localparam logic [1:0] ByteIdx1 = 2'd1;
  localparam logic [1:0] ByteIdx2 = 2'd2;

  localparam logic [1:0] LaneB = 2'd0;
  localparam logic [1:0] LaneG = 2'd1;
  localparam logic [1:0] LaneR = 2'd2;

  function automatic logic [7:0] select_lane(input logic [23:0] px, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      LaneB:   b = px[7:0];
      LaneG:   b = px[15:8];
      default: b = px[23:16];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// Single-clock FIFO with registered level; pushes when full and pops when empty are ignored.
// Depth must be a power of two so the pointers wrap naturally.
module pixel_sync_fifo #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           wdata,
  output logic [Width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] level
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LvlW'(Depth));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pixel_stream_serializer.sv
// Buffers a 24-bit pixel stream and emits it as bytes under valid/ready with raster flags.
// Define PIXEL_SER_BGR_EN to emit B,G,R instead of R,G,B.
module pixel_stream_serializer
  import pixel_ser_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [23:0]                     pixel_in,
  input  logic                            pixel_valid_in,
  output logic [7:0]                      byte_out,
  output logic                            byte_valid,
  input  logic                            byte_ready,
  output logic                            sof_out,
  output logic                            eol_out,
  output logic                            eof_out,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] XLast = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_HEIGHT - 1);

  function automatic logic [1:0] lane_of(input logic [1:0] idx);
    logic [1:0] lane;
`ifdef PIXEL_SER_BGR_EN
    case (idx)
      ByteIdx0: lane = LaneB;
      ByteIdx1: lane = LaneG;
      default:  lane = LaneR;
    endcase
`else
    case (idx)
      ByteIdx0: lane = LaneR;
      ByteIdx1: lane = LaneG;
      default:  lane = LaneB;
    endcase
`endif
    return lane;
  endfunction

  ser_state_e    state_q, state_d;
  logic [23:0]   hold_q, hold_d;
  logic [7:0]    byte_q, byte_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          overflow_q;
  logic          fifo_pop, fifo_full, fifo_empty, hs;
  logic [23:0]   fifo_rdata;

  pixel_sync_fifo #(
    .Width (24),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pixel_valid_in),
    .pop   (fifo_pop),
    .wdata (pixel_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign byte_valid = (state_q != StIdle);
  assign byte_out   = byte_q;
  assign hs         = byte_valid && byte_ready;
  assign overflow   = overflow_q;

  assign sof_out = byte_valid && (state_q == StByte0) && (x_q == '0) && (y_q == '0);
  assign eol_out = byte_valid && (state_q == StByte2) && (x_q == XLast);
  assign eof_out = eol_out && (y_q == YLast);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    byte_d   = byte_q;
    x_d      = x_q;
    y_d      = y_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_rdata;
          byte_d   = select_lane(fifo_rdata, lane_of(ByteIdx0));
          state_d  = StByte0;
        end
      end
      StByte0: begin
        if (hs) begin
          byte_d  = select_lane(hold_q, lane_of(ByteIdx1));
          state_d = StByte1;
        end
      end
      StByte1: begin
        if (hs) begin
          byte_d  = select_lane(hold_q, lane_of(ByteIdx2));
          state_d = StByte2;
        end
      end
      StByte2: begin
        if (hs) begin
          if (x_q == XLast) begin
            x_d = '0;
            y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          // Chain straight into the next pixel so a busy stream has no bubble.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            hold_d   = fifo_rdata;
            byte_d   = select_lane(fifo_rdata, lane_of(ByteIdx0));
            state_d  = StByte0;
          end else begin
            byte_d  = '0;
            state_d = StIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      byte_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (pixel_valid_in && fifo_full) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_stream_serializer.sv
// Directed self-checking bench for pixel_stream_serializer (4x2 frame, 4-deep FIFO).
module tb_pixel_stream_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pixel_in;
  logic        pixel_valid_in;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        sof_out, eol_out, eof_out, overflow;
  logic [2:0]  fifo_level;

  pixel_stream_serializer #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_in       (pixel_in),
    .pixel_valid_in (pixel_valid_in),
    .byte_out       (byte_out),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .sof_out        (sof_out),
    .eol_out        (eol_out),
    .eof_out        (eof_out),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] px;
    logic [7:0]  e0, e1, e2;
    logic        sof, eol, eof;
  } vec_t;

  vec_t        tbl [9];
  int          total = 0;
  int          passed = 0;
  logic [23:0] bs;
  logic [2:0]  sf, el, ef;
  int          got;
  logic [7:0]  rx [20];
  logic [23:0] ovf_px [6];
  logic [7:0]  ex0, ex2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_byte(input logic [23:0] px, input int idx);
`ifdef PIXEL_SER_BGR_EN
    if (idx == 0) return px[7:0];
    if (idx == 1) return px[15:8];
    return px[23:16];
`else
    if (idx == 0) return px[23:16];
    if (idx == 1) return px[15:8];
    return px[7:0];
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_and_collect(input logic [23:0] px, output logic [23:0] b,
                                  output logic [2:0] s, output logic [2:0] l,
                                  output logic [2:0] f, output int n);
    n = 0; b = '0; s = '0; l = '0; f = '0;
    byte_ready = 1'b1;
    pixel_in = px;
    pixel_valid_in = 1'b1;
    tick();
    pixel_valid_in = 1'b0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      if (byte_valid) begin
        b[23 - 8*n -: 8] = byte_out;
        s[n] = sof_out;
        l[n] = eol_out;
        f[n] = eof_out;
        n++;
      end
      tick();
    end
  endtask

  initial begin
    tbl[0] = '{24'h123456, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{24'hAABBCC, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{24'h010203, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{24'h0A0B0C, 8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{24'h102030, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{24'h405060, 8'h40, 8'h50, 8'h60, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{24'h708090, 8'h70, 8'h80, 8'h90, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{24'hA0B0C0, 8'hA0, 8'hB0, 8'hC0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{24'hFFEEDD, 8'hFF, 8'hEE, 8'hDD, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) ovf_px[i] = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)};

    rst = 1'b1;
    pixel_in = '0;
    pixel_valid_in = 1'b0;
    byte_ready = 1'b0;
    do_reset();

    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'd0);
    chk("rst_flags", {29'd0, sof_out, eol_out, eof_out}, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);

    // Single pixel, ready held high: check latency and byte sequence.
    byte_ready = 1'b1;
    pixel_in = 24'h123456;
    pixel_valid_in = 1'b1;
    tick();
    pixel_valid_in = 1'b0;
    chk("lat_level1", 32'(fifo_level), 32'd1);
    chk("lat_valid0", 32'(byte_valid), 32'd0);
    tick();
    chk("single_b0", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, exp_byte(24'h123456, 0)});
    chk("single_sof", 32'(sof_out), 32'd1);
    tick();
    chk("single_b1", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, exp_byte(24'h123456, 1)});
    tick();
    chk("single_b2", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, exp_byte(24'h123456, 2)});
    chk("single_b2_flags", {29'd0, sof_out, eol_out, eof_out}, 32'd0);
    tick();
    chk("single_idle", 32'(byte_valid), 32'd0);

    // Stall on the middle byte.
    do_reset();
    byte_ready = 1'b0;
    pixel_in = 24'h123456;
    pixel_valid_in = 1'b1;
    tick();
    pixel_valid_in = 1'b0;
    tick();
    chk("stall_b0", 32'(byte_out), 32'(exp_byte(24'h123456, 0)));
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, exp_byte(24'h123456, 1)});
      tick();
    end
    chk("stall_hold_last", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, exp_byte(24'h123456, 1)});
    byte_ready = 1'b1;
    tick();
    chk("stall_b2", 32'(byte_out), 32'(exp_byte(24'h123456, 2)));
    tick();
    chk("stall_idle", 32'(byte_valid), 32'd0);

    // Raster walk through a full 4x2 frame and into the next.
    do_reset();
    for (int i = 0; i < 9; i++) begin
`ifdef PIXEL_SER_BGR_EN
      ex0 = tbl[i].e2;
      ex2 = tbl[i].e0;
`else
      ex0 = tbl[i].e0;
      ex2 = tbl[i].e2;
`endif
      send_and_collect(tbl[i].px, bs, sf, el, ef, got);
      chk("vec_count", 32'(got), 32'd3);
      chk("vec_bytes", 32'(bs), {8'd0, ex0, tbl[i].e1, ex2});
      chk("vec_sof", 32'(sf), {29'd0, 2'b00, tbl[i].sof});
      chk("vec_eol", 32'(el), {29'd0, tbl[i].eol, 2'b00});
      chk("vec_eof", 32'(ef), {29'd0, tbl[i].eof, 2'b00});
    end

    // Overflow: six back-to-back pixels with the consumer stalled.
    do_reset();
    byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pixel_in = ovf_px[i];
      pixel_valid_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    byte_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (byte_valid && got < 20) begin
        rx[got] = byte_out;
        got++;
      end
      tick();
    end
    chk("ovf_count", 32'(got), 32'd15);
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < 3; k++)
        chk("ovf_byte", 32'(rx[3*p + k]), 32'(exp_byte(ovf_px[p], k)));
    chk("ovf_drain_level", 32'(fifo_level), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-transfer with three pixels queued; raster position is non-zero here.
    byte_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pixel_in = ovf_px[i];
      pixel_valid_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    byte_ready = 1'b1;
    tick();
    chk("mid_level", 32'(fifo_level), 32'd3);
    chk("mid_b1", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, exp_byte(ovf_px[0], 1)});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(byte_valid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    send_and_collect(24'hAABBCC, bs, sf, el, ef, got);
    chk("mid_next_count", 32'(got), 32'd3);
    chk("mid_next_sof", 32'(sf), 32'd1);
    chk("mid_next_bytes", 32'(bs),
        {8'd0, exp_byte(24'hAABBCC, 0), exp_byte(24'hAABBCC, 1), exp_byte(24'hAABBCC, 2)});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
